// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It resolves load-use interlocks, branch/jump redirects taken in MEM and
// multi-cycle data-memory waits. It also keeps saturating stall and redirect
// counters.
//
// Handshake: the data memory is a req/ready pair. The MEM stage holds dmem_req
// high for as long as its access is pending. An access completes in the cycle
// in which dmem_ready is high, and the pipeline is frozen in every cycle before
// that. The FSM state is visible on mem_busy (1 = MEM_WAIT).
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             pc_sel,
  output logic             mem_busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              CW         = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0]   WAIT_MAX_C = CW'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_wait_ctr;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_taken;
  logic w_lu;
  logic w_freeze;
  logic w_redirect;

  // The load-use interlock never fires on r0. A redirect needs a branch with zero
  // set, or a jump. The freeze covers every cycle in which a memory access is
  // pending.
  always_comb begin
    w_taken    = (mem_branch & mem_zero) | mem_jump;
    w_lu       = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    w_freeze   = ((r_state == ST_MEM_WAIT) & ~dmem_ready) |
                 ((r_state == ST_RUN) & dmem_req & ~dmem_ready);
    w_redirect = w_taken & ~w_freeze;
  end

  // Priority-ordered pipeline controls. Reset forces bubbles into every stage.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    exmem_flush = 1'b0;
    pc_sel      = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (w_taken) begin
      // The dependent instruction is squashed, so a pending load-use does not matter.
      pc_sel      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  // FSM for the RUN / MEM_WAIT sequence. It carries the wait counter and the
  // sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_ctr    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_ctr <= CW'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state <= ST_RUN;
          end else if (r_wait_ctr == WAIT_MAX_C) begin
            // A timed-out access is treated as complete so the pipeline can move on.
            r_state       <= ST_RUN;
            r_err_timeout <= 1'b1;
          end else begin
            r_wait_ctr <= r_wait_ctr + CW'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating performance counters for stall cycles and redirect events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_busy    = (r_state == ST_MEM_WAIT);
  assign err_timeout = r_err_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. It runs directed scenarios followed by random
// traffic. A behavioural model is compared with the DUT at every falling edge.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 6;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_memread = 0, mem_branch = 0, mem_zero = 0, mem_jump = 0;
  logic dmem_req = 0, dmem_ready = 0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_write, exmem_flush, pc_sel, mem_busy, err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .pc_sel(pc_sel), .mem_busy(mem_busy), .err_timeout(err_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_in_wait: an access is outstanding after its first cycle. m_waited: cycles
  // spent in the wait state so far.
  bit m_in_wait = 0;
  int m_waited  = 0;
  bit m_err     = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  // Compare process: predict this cycle's controls, check, then advance the model.
  always @(negedge clk) begin
    bit taken, lu, frozen;
    bit e_pcw, e_ifw, e_iff, e_idw, e_idf, e_exw, e_exf, e_sel;
    taken  = (mem_branch && mem_zero) || mem_jump;
    lu     = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    frozen = !dmem_ready && (m_in_wait || dmem_req);
    if (!rst_n) begin
      {e_pcw, e_ifw, e_idw, e_exw} = 4'b0000;
      {e_iff, e_idf, e_exf, e_sel} = 4'b1110;
      m_in_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else if (frozen) begin
      {e_pcw, e_ifw, e_idw, e_exw} = 4'b0000;
      {e_iff, e_idf, e_exf, e_sel} = 4'b0000;
    end else if (taken) begin
      {e_pcw, e_ifw, e_idw, e_exw} = 4'b1111;
      {e_iff, e_idf, e_exf, e_sel} = 4'b1111;
    end else if (lu) begin
      {e_pcw, e_ifw, e_idw, e_exw} = 4'b0011;
      {e_iff, e_idf, e_exf, e_sel} = 4'b0100;
    end else begin
      {e_pcw, e_ifw, e_idw, e_exw} = 4'b1111;
      {e_iff, e_idf, e_exf, e_sel} = 4'b0000;
    end
    chk("pc_write",    32'(pc_write),    32'(e_pcw));
    chk("ifid_write",  32'(ifid_write),  32'(e_ifw));
    chk("ifid_flush",  32'(ifid_flush),  32'(e_iff));
    chk("idex_write",  32'(idex_write),  32'(e_idw));
    chk("idex_flush",  32'(idex_flush),  32'(e_idf));
    chk("exmem_write", 32'(exmem_write), 32'(e_exw));
    chk("exmem_flush", 32'(exmem_flush), 32'(e_exf));
    chk("pc_sel",      32'(pc_sel),      32'(e_sel));
    chk("mem_busy",    32'(mem_busy),    32'(m_in_wait));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    chk("flush_cnt",   32'(flush_cnt),   32'(m_flush));
    if (rst_n) begin
      if (!e_pcw) m_stall = (m_stall < CNT_SAT) ? m_stall + 1 : CNT_SAT;
      if (!frozen && taken) m_flush = (m_flush < CNT_SAT) ? m_flush + 1 : CNT_SAT;
      if (m_in_wait) begin
        if (dmem_ready) m_in_wait = 0;
        else if (m_waited == WAIT_MAX) begin m_in_wait = 0; m_err = 1; end
        else m_waited++;
      end else if (dmem_req && !dmem_ready) begin
        m_in_wait = 1; m_waited = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    {ex_memread, mem_branch, mem_zero, mem_jump, dmem_req, dmem_ready} = '0;
    id_rs = 0; id_rt = 0; ex_rt = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); step(); step(); rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd7;
    idle();
    #2;
    @(negedge clk);
    chk("lit_reset_pcw",  32'(pc_write),    32'd0);
    chk("lit_reset_exf",  32'(exmem_flush), 32'd1);
    step(); rst_n = 1;

    // T1: load-use on rs
    ex_memread = 1; ex_rt = 5; id_rs = 5; id_rt = 3;
    @(negedge clk);
    chk("lit_t1_pcw", 32'(pc_write),   32'd0);
    chk("lit_t1_idf", 32'(idex_flush), 32'd1);
    step(); idle();
    @(negedge clk);
    chk("lit_t1_stall", 32'(stall_cnt), 32'd1);
    chk("lit_t1_pcw_after", 32'(pc_write), 32'd1);
    step();

    // T2: r0 is exempt from the interlock
    ex_memread = 1; ex_rt = 0; id_rs = 0; id_rt = 0;
    @(negedge clk);
    chk("lit_t2_pcw", 32'(pc_write), 32'd1);
    chk("lit_t2_idw", 32'(idex_write), 32'd1);
    step(); idle();

    // T3: a redirect beats load-use, then a branch that is not taken
    mem_branch = 1; mem_zero = 1; ex_memread = 1; ex_rt = 2; id_rt = 2;
    @(negedge clk);
    chk("lit_t3_sel", 32'(pc_sel), 32'd1);
    chk("lit_t3_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 32'd7);
    chk("lit_t3_pcw", 32'(pc_write), 32'd1);
    step(); idle(); mem_branch = 1; mem_zero = 0;
    @(negedge clk);
    chk("lit_t3_flushcnt", 32'(flush_cnt), 32'd1);
    chk("lit_t3_nt_sel", 32'(pc_sel), 32'd0);
    step(); idle();

    // T4: memory ready in the fourth cycle of the access
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_t4_frozen", 32'(pc_write), 32'd0);
      step();
    end
    dmem_ready = 1;
    @(negedge clk);
    chk("lit_t4_release", 32'(pc_write), 32'd1);
    step(); idle();
    @(negedge clk);
    chk("lit_t4_busy_after", 32'(mem_busy), 32'd0);
    chk("lit_t4_stall", 32'(stall_cnt), 32'd4);
    step();

    // T5: the access times out because ready never arrives
    dmem_req = 1; step(); dmem_req = 0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      chk("lit_t5_err_low", 32'(err_timeout), 32'd0);
      step();
    end
    @(negedge clk);
    chk("lit_t5_err", 32'(err_timeout), 32'd1);
    chk("lit_t5_run", 32'(mem_busy), 32'd0);
    chk("lit_t5_stall", 32'(stall_cnt), 32'd9);
    repeat (3) step();
    @(negedge clk);
    chk("lit_t5_sticky", 32'(err_timeout), 32'd1);

    // T6: reset asserted in the middle of a wait
    step(); dmem_req = 1; step(); step();
    rst_n = 0; #1;
    chk("lit_t6_busy", 32'(mem_busy), 32'd0);
    chk("lit_t6_stall", 32'(stall_cnt), 32'd0);
    chk("lit_t6_err", 32'(err_timeout), 32'd0);
    chk("lit_t6_flush", 32'(ifid_flush), 32'd1);
    chk("lit_t6_write", 32'(exmem_write), 32'd0);
    idle(); step(); rst_n = 1;

    // Saturation: a load-use held for many cycles
    ex_memread = 1; ex_rt = 9; id_rs = 9;
    repeat (CNT_SAT + 10) step();
    @(negedge clk);
    chk("lit_sat_stall", 32'(stall_cnt), CNT_SAT);
    step(); idle();

    // Random traffic with rare resets
    for (int c = 0; c < 3000; c++) begin
      id_rs      = regs[$urandom_range(0, 3)];
      id_rt      = regs[$urandom_range(0, 3)];
      ex_rt      = regs[$urandom_range(0, 3)];
      ex_memread = ($urandom_range(0, 2) == 0);
      mem_branch = ($urandom_range(0, 4) == 0);
      mem_zero   = $urandom_range(0, 1);
      mem_jump   = ($urandom_range(0, 9) == 0);
      dmem_req   = ($urandom_range(0, 4) == 0);
      dmem_ready = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1; idle(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
